// File: rtl/aqp_ovl_writer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aqp_ovl_writer_if : host write bus (valid/ready) into the overlay writer
// Revision: 1.0
// ---------------------------------------------------------------------------
interface aqp_ovl_writer_if;
  logic        host_valid;
  logic        host_ready;
  logic [1:0]  host_sel;
  logic [10:0] host_addr;
  logic [15:0] host_wrdata;

  modport master (
    output host_valid, host_sel, host_addr, host_wrdata,
    input  host_ready
  );

  modport slave (
    input  host_valid, host_sel, host_addr, host_wrdata,
    output host_ready
  );
endinterface
`default_nettype wire

// File: rtl/aqp_ovl_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aqp_ovl_writer : write controller for overlay text/font/palette RAMs with a
// text fill engine. Optional power-up text clear: AQP_OVL_RESET_CLEAR_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module aqp_ovl_writer #(
  parameter int TEXT_WORDS = 1024,
  parameter int MAX_COUNT  = 1024
) (
  input  wire logic          ovl_clk,
  input  wire logic          ovl_rst_n,
  aqp_ovl_writer_if.slave    host,
  output logic [9:0]         ovl_text_addr,
  output logic [15:0]        ovl_text_wrdata,
  output logic               ovl_text_wr,
  output logic [10:0]        ovl_font_addr,
  output logic [7:0]         ovl_font_wrdata,
  output logic               ovl_font_wr,
  output logic [3:0]         ovl_palette_addr,
  output logic [15:0]        ovl_palette_wrdata,
  output logic               ovl_palette_wr,
  output logic               fill_busy,
  output logic               fill_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_INIT = 2'd2
  } state_t;

  localparam logic [9:0]  C_ADDR_MASK = 10'(TEXT_WORDS - 1);
  localparam logic [10:0] C_MAX_COUNT = 11'(MAX_COUNT);
`ifdef AQP_OVL_RESET_CLEAR_EN
  localparam state_t C_RESET_STATE = S_INIT;
`else
  localparam state_t C_RESET_STATE = S_IDLE;
`endif

  state_t      state_q, state_d;
  logic [9:0]  text_addr_q, text_addr_d;
  logic [15:0] text_wrdata_q, text_wrdata_d;
  logic        text_wr_q, text_wr_d;
  logic [10:0] font_addr_q, font_addr_d;
  logic [7:0]  font_wrdata_q, font_wrdata_d;
  logic        font_wr_q, font_wr_d;
  logic [3:0]  pal_addr_q, pal_addr_d;
  logic [15:0] pal_wrdata_q, pal_wrdata_d;
  logic        pal_wr_q, pal_wr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] value_q, value_d;
  logic [9:0]  start_q, start_d;
  logic [10:0] remaining_q, remaining_d;

  logic        w_side_sel;
  logic        w_accept;
  logic [10:0] w_count;

  // Font/palette ports never conflict with the fill engine, so only text and
  // control traffic is gated by the state.
  assign w_side_sel      = (host.host_sel == 2'd1) || (host.host_sel == 2'd2);
  assign host.host_ready = ovl_rst_n && (w_side_sel || (state_q == S_IDLE));
  assign w_accept        = host.host_valid && host.host_ready;
  assign w_count         = (host.host_wrdata[10:0] > C_MAX_COUNT) ? C_MAX_COUNT
                                                                  : host.host_wrdata[10:0];

  always_comb begin
    state_d       = state_q;
    text_addr_d   = text_addr_q;
    text_wrdata_d = text_wrdata_q;
    text_wr_d     = 1'b0;
    font_addr_d   = font_addr_q;
    font_wrdata_d = font_wrdata_q;
    font_wr_d     = 1'b0;
    pal_addr_d    = pal_addr_q;
    pal_wrdata_d  = pal_wrdata_q;
    pal_wr_d      = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    value_d       = value_q;
    start_d       = start_q;
    remaining_d   = remaining_q;

    if (w_accept) begin
      case (host.host_sel)
        2'd0: begin
          text_wr_d     = 1'b1;
          text_addr_d   = host.host_addr[9:0] & C_ADDR_MASK;
          text_wrdata_d = host.host_wrdata;
        end
        2'd1: begin
          font_wr_d     = 1'b1;
          font_addr_d   = host.host_addr;
          font_wrdata_d = host.host_wrdata[7:0];
        end
        2'd2: begin
          pal_wr_d      = 1'b1;
          pal_addr_d    = host.host_addr[3:0];
          pal_wrdata_d  = host.host_wrdata;
        end
        default: begin
          case (host.host_addr[1:0])
            2'd0: value_d = host.host_wrdata;
            2'd1: start_d = host.host_wrdata[9:0] & C_ADDR_MASK;
            2'd2: begin
              if (w_count == 11'd0) begin
                done_d = 1'b1;
              end else begin
                // First fill word goes out in the cycle right after the trigger.
                state_d       = S_FILL;
                text_wr_d     = 1'b1;
                text_addr_d   = start_q;
                text_wrdata_d = value_q;
                remaining_d   = w_count - 11'd1;
                busy_d        = 1'b1;
              end
            end
            default: ;
          endcase
        end
      endcase
    end

    case (state_q)
      S_FILL: begin
        if (remaining_q != 11'd0) begin
          text_wr_d   = 1'b1;
          text_addr_d = (text_addr_q + 10'd1) & C_ADDR_MASK;
          remaining_d = remaining_q - 11'd1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_INIT: begin
        if (!text_wr_q) begin
          text_wr_d     = 1'b1;
          text_addr_d   = 10'd0;
          text_wrdata_d = 16'h0000;
          busy_d        = 1'b1;
        end else if (text_addr_q != C_ADDR_MASK) begin
          text_wr_d   = 1'b1;
          text_addr_d = text_addr_q + 10'd1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ovl_clk) begin
    if (!ovl_rst_n) begin
      state_q       <= C_RESET_STATE;
      text_addr_q   <= '0;
      text_wrdata_q <= '0;
      text_wr_q     <= 1'b0;
      font_addr_q   <= '0;
      font_wrdata_q <= '0;
      font_wr_q     <= 1'b0;
      pal_addr_q    <= '0;
      pal_wrdata_q  <= '0;
      pal_wr_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      value_q       <= '0;
      start_q       <= '0;
      remaining_q   <= '0;
    end else begin
      state_q       <= state_d;
      text_addr_q   <= text_addr_d;
      text_wrdata_q <= text_wrdata_d;
      text_wr_q     <= text_wr_d;
      font_addr_q   <= font_addr_d;
      font_wrdata_q <= font_wrdata_d;
      font_wr_q     <= font_wr_d;
      pal_addr_q    <= pal_addr_d;
      pal_wrdata_q  <= pal_wrdata_d;
      pal_wr_q      <= pal_wr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      value_q       <= value_d;
      start_q       <= start_d;
      remaining_q   <= remaining_d;
    end
  end

  assign ovl_text_addr      = text_addr_q;
  assign ovl_text_wrdata    = text_wrdata_q;
  assign ovl_text_wr        = text_wr_q;
  assign ovl_font_addr      = font_addr_q;
  assign ovl_font_wrdata    = font_wrdata_q;
  assign ovl_font_wr        = font_wr_q;
  assign ovl_palette_addr   = pal_addr_q;
  assign ovl_palette_wrdata = pal_wrdata_q;
  assign ovl_palette_wr     = pal_wr_q;
  assign fill_busy          = busy_q;
  assign fill_done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_aqp_ovl_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_aqp_ovl_writer : scoreboard bench for aqp_ovl_writer
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_aqp_ovl_writer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aqp_ovl_writer_if hif ();

  logic [9:0]  ovl_text_addr;
  logic [15:0] ovl_text_wrdata;
  logic        ovl_text_wr;
  logic [10:0] ovl_font_addr;
  logic [7:0]  ovl_font_wrdata;
  logic        ovl_font_wr;
  logic [3:0]  ovl_palette_addr;
  logic [15:0] ovl_palette_wrdata;
  logic        ovl_palette_wr;
  logic        fill_busy;
  logic        fill_done;

  aqp_ovl_writer #(.TEXT_WORDS(1024), .MAX_COUNT(1024)) dut (
    .ovl_clk            (clk),
    .ovl_rst_n          (rst_n),
    .host               (hif),
    .ovl_text_addr      (ovl_text_addr),
    .ovl_text_wrdata    (ovl_text_wrdata),
    .ovl_text_wr        (ovl_text_wr),
    .ovl_font_addr      (ovl_font_addr),
    .ovl_font_wrdata    (ovl_font_wrdata),
    .ovl_font_wr        (ovl_font_wr),
    .ovl_palette_addr   (ovl_palette_addr),
    .ovl_palette_wrdata (ovl_palette_wrdata),
    .ovl_palette_wr     (ovl_palette_wr),
    .fill_busy          (fill_busy),
    .fill_done          (fill_done)
  );

`ifdef AQP_OVL_RESET_CLEAR_EN
  localparam bit C_INIT = 1'b1;
`else
  localparam bit C_INIT = 1'b0;
`endif

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  logic [25:0] text_q[$];
  logic [18:0] font_q[$];
  logic [19:0] pal_q[$];

  int text_cnt, font_cnt, pal_cnt, busy_cnt, done_cnt;
  int done_cyc, first_text_cyc, last_text_cyc, pal_cyc;
  logic [15:0] sh_value;
  logic [9:0]  sh_start;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every strobe is matched against the scoreboard queues.
  always @(negedge clk) begin
    if (ovl_text_wr === 1'b1) begin
      logic [25:0] e;
      text_cnt++;
      if (text_cnt == 1) first_text_cyc = cyc;
      last_text_cyc = cyc;
      checks++;
      if (text_q.size() == 0)
        $display("FAIL text_unexpected: got addr=%0d data=%h, required no strobe",
                 ovl_text_addr, ovl_text_wrdata);
      else begin
        e = text_q.pop_front();
        if ({ovl_text_addr, ovl_text_wrdata} !== e)
          $display("FAIL text_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   ovl_text_addr, ovl_text_wrdata, e[25:16], e[15:0]);
        else passes++;
      end
    end
    if (ovl_font_wr === 1'b1) begin
      logic [18:0] e;
      font_cnt++;
      checks++;
      if (font_q.size() == 0)
        $display("FAIL font_unexpected: got addr=%0d data=%h, required no strobe",
                 ovl_font_addr, ovl_font_wrdata);
      else begin
        e = font_q.pop_front();
        if ({ovl_font_addr, ovl_font_wrdata} !== e)
          $display("FAIL font_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   ovl_font_addr, ovl_font_wrdata, e[18:8], e[7:0]);
        else passes++;
      end
    end
    if (ovl_palette_wr === 1'b1) begin
      logic [19:0] e;
      pal_cnt++;
      pal_cyc = cyc;
      checks++;
      if (pal_q.size() == 0)
        $display("FAIL pal_unexpected: got addr=%0d data=%h, required no strobe",
                 ovl_palette_addr, ovl_palette_wrdata);
      else begin
        e = pal_q.pop_front();
        if ({ovl_palette_addr, ovl_palette_wrdata} !== e)
          $display("FAIL pal_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   ovl_palette_addr, ovl_palette_wrdata, e[19:16], e[15:0]);
        else passes++;
      end
    end
    if (fill_busy === 1'b1) busy_cnt++;
    if (fill_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_stats();
    text_cnt = 0; font_cnt = 0; pal_cnt = 0; busy_cnt = 0; done_cnt = 0;
    done_cyc = -1; first_text_cyc = -1; last_text_cyc = -1; pal_cyc = -1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int limit);
    for (int i = 0; i < limit && done_cnt < target; i++) @(posedge clk);
    #1;
  endtask

  task automatic push_init();
    for (int i = 0; i < 1024; i++) text_q.push_back({10'(i), 16'h0000});
  endtask

  // Drives one host write, holding valid until accepted; pushes the expected
  // RAM activity at the acceptance cycle. Called at posedge+1.
  task automatic host_write(input logic [1:0] sel, input logic [10:0] addr,
                            input logic [15:0] data, output int acc_cyc);
    hif.host_valid  = 1'b1;
    hif.host_sel    = sel;
    hif.host_addr   = addr;
    hif.host_wrdata = data;
    acc_cyc = -1;
    for (int i = 0; i < 3000; i++) begin
      #1;
      if (hif.host_ready === 1'b1) begin
        acc_cyc = cyc;
        case (sel)
          2'd0: text_q.push_back({addr[9:0], data});
          2'd1: font_q.push_back({addr, data[7:0]});
          2'd2: pal_q.push_back({addr[3:0], data});
          default: begin
            if (addr[1:0] == 2'd0) sh_value = data;
            else if (addr[1:0] == 2'd1) sh_start = data[9:0];
            else if (addr[1:0] == 2'd2) begin
              int n;
              n = (data[10:0] > 11'd1024) ? 1024 : int'(data[10:0]);
              for (int k = 0; k < n; k++) text_q.push_back({sh_start + 10'(k), sh_value});
            end
          end
        endcase
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
    end
    hif.host_valid = 1'b0;
    checks++;
    if (acc_cyc < 0) begin
      $display("FAIL host_write_timeout: sel=%0d never accepted, required acceptance", sel);
      #1;
    end else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hif.host_valid = 1'b1; hif.host_sel = 2'd1; hif.host_addr = '0; hif.host_wrdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (hif.host_ready !== 1'b0) $display("FAIL reset_ready: got %b, required 0", hif.host_ready);
    else passes++;
    checks++;
    if ({ovl_text_addr, ovl_text_wrdata, ovl_text_wr, ovl_font_addr, ovl_font_wrdata,
         ovl_font_wr, ovl_palette_addr, ovl_palette_wrdata, ovl_palette_wr,
         fill_busy, fill_done} !== '0)
      $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    else passes++;
    hif.host_valid = 1'b0;
    sh_value = '0; sh_start = '0;
    clear_stats();
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    int r, a1, a0;
    r = cyc;
    clear_stats();
    push_init();
    host_write(2'd1, 11'd9, 16'h0055, a1);
    host_write(2'd0, 11'd7, 16'h1234, a0);
    wait_cycles(3);
    checks++;
    if (a1 !== r) $display("FAIL init_font_accept: got cycle %0d, required %0d", a1, r);
    else passes++;
    checks++;
    if (a0 !== r + 1025) $display("FAIL init_text_wait: got cycle %0d, required %0d", a0, r + 1025);
    else passes++;
    checks++;
    if (first_text_cyc !== r + 1) $display("FAIL init_first: got %0d, required %0d", first_text_cyc, r + 1);
    else passes++;
    checks++;
    if (busy_cnt !== 1024 || done_cnt !== 1)
      $display("FAIL init_busy_done: got busy=%0d done=%0d, required 1024 1", busy_cnt, done_cnt);
    else passes++;
  endtask

  task automatic test_text_write();
    int a;
    clear_stats();
    host_write(2'd0, 11'd5, 16'h1F41, a);
    wait_cycles(3);
    checks++;
    if (text_cnt !== 1 || last_text_cyc !== a + 1)
      $display("FAIL text_single: got cnt=%0d cyc=%0d, required 1 %0d", text_cnt, last_text_cyc, a + 1);
    else passes++;
    checks++;
    if (font_cnt !== 0 || pal_cnt !== 0)
      $display("FAIL text_other_strobes: got font=%0d pal=%0d, required 0 0", font_cnt, pal_cnt);
    else passes++;
  endtask

  task automatic test_font_pal();
    int a;
    clear_stats();
    host_write(2'd1, 11'h7FF, 16'hABCD, a);
    host_write(2'd2, 11'h7F3, 16'h1234, a);
    wait_cycles(3);
    checks++;
    if (font_cnt !== 1 || pal_cnt !== 1 || text_cnt !== 0)
      $display("FAIL font_pal_counts: got font=%0d pal=%0d text=%0d, required 1 1 0",
               font_cnt, pal_cnt, text_cnt);
    else passes++;
  endtask

  task automatic test_fill_wrap();
    int a, c, pa, ta;
    clear_stats();
    host_write(2'd3, 11'd0, 16'h0720, a);
    host_write(2'd3, 11'd1, 16'd1020, a);
    host_write(2'd3, 11'd2, 16'd8, c);
    host_write(2'd2, 11'd3, 16'hF00F, pa);
    host_write(2'd0, 11'h12, 16'h5A5A, ta);
    wait_cycles(3);
    checks++;
    if (pa !== c + 1) $display("FAIL fill_pal_accept: got cycle %0d, required %0d", pa, c + 1);
    else passes++;
    checks++;
    if (pal_cyc !== c + 2) $display("FAIL fill_pal_strobe: got cycle %0d, required %0d", pal_cyc, c + 2);
    else passes++;
    checks++;
    if (ta !== c + 9) $display("FAIL fill_text_wait: got cycle %0d, required %0d", ta, c + 9);
    else passes++;
    checks++;
    if (first_text_cyc !== c + 1 || text_cnt !== 9)
      $display("FAIL fill_strobes: got first=%0d cnt=%0d, required %0d 9", first_text_cyc, text_cnt, c + 1);
    else passes++;
    checks++;
    if (busy_cnt !== 8) $display("FAIL fill_busy: got %0d cycles, required 8", busy_cnt);
    else passes++;
    checks++;
    if (done_cnt !== 1 || done_cyc !== c + 9)
      $display("FAIL fill_done: got cnt=%0d cyc=%0d, required 1 %0d", done_cnt, done_cyc, c + 9);
    else passes++;
  endtask

  task automatic test_count_zero();
    int c;
    clear_stats();
    host_write(2'd3, 11'd2, 16'd0, c);
    wait_cycles(3);
    checks++;
    if (text_cnt !== 0 || busy_cnt !== 0)
      $display("FAIL zero_strobes: got text=%0d busy=%0d, required 0 0", text_cnt, busy_cnt);
    else passes++;
    checks++;
    if (done_cnt !== 1 || done_cyc !== c + 1)
      $display("FAIL zero_done: got cnt=%0d cyc=%0d, required 1 %0d", done_cnt, done_cyc, c + 1);
    else passes++;
  endtask

  task automatic test_clamp();
    int c, a;
    clear_stats();
    host_write(2'd3, 11'd2, 16'd2047, c);
    host_write(2'd3, 11'd3, 16'hFFFF, a);
    wait_done(1, 1200);
    wait_cycles(2);
    checks++;
    if (text_cnt !== 1024 || busy_cnt !== 1024)
      $display("FAIL clamp_count: got text=%0d busy=%0d, required 1024 1024", text_cnt, busy_cnt);
    else passes++;
    checks++;
    if (done_cyc !== c + 1025) $display("FAIL clamp_done: got cycle %0d, required %0d", done_cyc, c + 1025);
    else passes++;
  endtask

  task automatic test_reset_mid_fill();
    int a, c;
    clear_stats();
    host_write(2'd3, 11'd0, 16'h3333, a);
    host_write(2'd3, 11'd1, 16'd100, a);
    host_write(2'd3, 11'd2, 16'd20, c);
    while (cyc < c + 3) wait_cycles(1);
    rst_n = 1'b0;
    wait_cycles(1);
    checks++;
    if ({ovl_text_wr, ovl_font_wr, ovl_palette_wr, fill_busy, fill_done,
         ovl_text_addr, ovl_text_wrdata} !== '0)
      $display("FAIL midreset_outputs: got nonzero outputs, required all 0");
    else passes++;
    checks++;
    if (text_cnt !== 3) $display("FAIL midreset_strobes: got %0d, required 3", text_cnt);
    else passes++;
    text_q.delete();
    sh_value = '0; sh_start = '0;
    clear_stats();
    rst_n = 1'b1;
    if (C_INIT) push_init();
    wait_cycles(C_INIT ? 1030 : 25);
    checks++;
    if (done_cnt !== int'(C_INIT) || text_cnt !== (C_INIT ? 1024 : 0))
      $display("FAIL midreset_after: got done=%0d text=%0d, required %0d %0d",
               done_cnt, text_cnt, int'(C_INIT), C_INIT ? 1024 : 0);
    else passes++;
    clear_stats();
    host_write(2'd3, 11'd2, 16'd3, c);
    host_write(2'd0, 11'd9, 16'hC0DE, a);
    wait_cycles(3);
    checks++;
    if (text_cnt !== 4 || done_cyc !== c + 4)
      $display("FAIL postreset_fill: got text=%0d done_cyc=%0d, required 4 %0d", text_cnt, done_cyc, c + 4);
    else passes++;
  endtask

  initial begin
    hif.host_valid = 1'b0; hif.host_sel = '0; hif.host_addr = '0; hif.host_wrdata = '0;
    clear_stats();
    test_reset();
    if (C_INIT) test_init();
    else begin
      wait_cycles(5);
      checks++;
      if (text_cnt !== 0) $display("FAIL no_init_strobes: got %0d, required 0", text_cnt);
      else passes++;
    end
    test_text_write();
    test_font_pal();
    test_fill_wrap();
    test_count_zero();
    test_clamp();
    test_reset_mid_fill();
    checks++;
    if (text_q.size() + font_q.size() + pal_q.size() !== 0)
      $display("FAIL scoreboard_drain: got %0d pending, required 0",
               text_q.size() + font_q.size() + pal_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aqp_ovl_writer.md
Name: aqp_ovl_writer

Overview:
- Single write-side controller for the overlay text, font and palette RAMs; it drives their write ports on ovl_clk.
- It accepts host writes over a valid/ready handshake and routes each one to the selected RAM.
- It contains a hardware fill engine that writes one 16-bit text word per cycle over an address range, used for clear-screen and region fills.
- While the engine owns the text write port, host text writes stall; font and palette writes continue.

Parameters:
- TEXT_WORDS, 1024, text RAM depth in words; addresses wrap modulo this value (power of two).
- MAX_COUNT, 1024, upper clamp for the fill count.

Ports:
- ovl_clk  in  1  clock; the only clock.
- ovl_rst_n  in  1  reset, synchronous, active-low.
- host_valid  in  1  host write request.
- host_ready  out  1  request accepted this cycle when high together with host_valid.
- host_sel  in  2  target select: 0=text, 1=font, 2=palette, 3=control.
- host_addr  in  11  word/byte address within the target.
- host_wrdata  in  16  write data; font uses [7:0].
- ovl_text_addr  out  10  text RAM write address.
- ovl_text_wrdata  out  16  text RAM write data.
- ovl_text_wr  out  1  text RAM write strobe.
- ovl_font_addr  out  11  font RAM write address.
- ovl_font_wrdata  out  8  font RAM write data.
- ovl_font_wr  out  1  font RAM write strobe.
- ovl_palette_addr  out  4  palette write address.
- ovl_palette_wrdata  out  16  palette write data.
- ovl_palette_wr  out  1  palette write strobe.
- fill_busy  out  1  fill engine active.
- fill_done  out  1  one-cycle pulse when a fill completes.

Behaviour:
- Reset (ovl_rst_n low at a clock edge) sets every output to 0: all strobes, addresses, data, fill_busy and fill_done. The fill registers (value, start, remaining) also clear to 0, and the state machine goes to IDLE. A reset in the middle of a fill aborts it with no further strobes and no fill_done pulse.
- All outputs are registered. A host write accepted in cycle N produces its strobe, address and data in cycle N+1 for exactly one cycle.
- host_ready:
  - high for sel 1 and sel 2 in every state except reset;
  - for sel 0 and sel 3, high only in IDLE.
- Font and palette address and data are the low bits of host_addr and host_wrdata.
- Control registers (sel 3, selected by host_addr[1:0]):
  - 0: fill value (16 bits).
  - 1: fill start (host_wrdata[9:0]).
  - 2: fill count (host_wrdata[10:0]); writing it triggers the fill.
  - 3: reserved; the write is accepted and ignored.
- Count rules: a written count above MAX_COUNT is clamped to MAX_COUNT. A count of 0 starts no fill and pulses fill_done in cycle N+1.
- State machine IDLE -> FILL when the count register is written in cycle N with count > 0.
- In FILL:
  - ovl_text_wr is high every cycle from N+1 through N+count, with data = fill value.
  - The address starts at fill start and increments by 1 each cycle, wrapping 1023 -> 0.
  - After the last write the state returns to IDLE. fill_busy is high from N+1 through N+count.
  - fill_done pulses in cycle N+count+1, the same cycle fill_busy falls.
- Font and palette strobes may be high in the same cycle as fill text strobes; the ports are independent.
- Host text writes are not buffered during FILL. They wait with valid held; the first one accepted is in the first IDLE cycle.
- A new trigger is accepted only in IDLE, so a fill is never restarted while running.
- Writes to value or start registers take effect on the next trigger only.

Optional Feature:
- Macro AQP_OVL_RESET_CLEAR_EN.
- Defined:
  - After reset is released, the block enters INIT.
  - INIT writes 0x0000 to all TEXT_WORDS text addresses 0..1023, one per cycle, starting in the first cycle after reset is released.
  - fill_busy is high during INIT. host_ready is low for sel 0 and sel 3, and font/palette writes are still accepted.
  - INIT -> IDLE after address 1023, with a fill_done pulse.
- Not defined: the block resets straight into IDLE and no text writes occur until the host issues them.

Test Plan:
- Host write sel=0 addr=5 data=0x1F41 in cycle N -> ovl_text_wr=1, addr=5, data=0x1F41 in cycle N+1 only; other strobes stay 0.
- Write value=0x0720, start=1020, count=8 -> 8 consecutive text strobes at 1020,1021,1022,1023,0,1,2,3 with data 0x0720; fill_busy high 8 cycles; fill_done pulses 1 cycle after the last strobe.
- During that fill, sel=0 request held -> host_ready=0 until IDLE. A concurrent sel=2 addr=3 data=0xF00F is accepted immediately and ovl_palette_wr fires mid-fill.
- count=0 -> no text strobes; fill_done pulses 1 cycle later. count=2047 -> clamped, exactly 1024 strobes.
- Drive ovl_rst_n low for 1 cycle at fill cycle 3 -> no strobes from the next cycle on, no fill_done, all outputs 0. Subsequent host writes work normally.
- With AQP_OVL_RESET_CLEAR_EN: release reset -> 1024 strobes of 0x0000 at 0..1023. A sel=0 request during INIT waits; a sel=1 request is accepted.
